// File: rtl/pattern_scan_ctrl.sv
// Scan sequencer with an overlapping serial pattern detector and match counter.
// Optional bit-budget timeout is enabled by defining SCAN_TIMEOUT_EN.
module pattern_scan_ctrl #(
  parameter int PATTERN_W = 5,
  parameter int CNT_W     = 8,
  parameter int MAX_BITS  = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [PATTERN_W-1:0] pattern,
  input  logic [CNT_W-1:0]     match_limit,
  input  logic                 abort,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  output logic                 busy,
  output logic                 done,
  output logic                 match,
  output logic [CNT_W-1:0]     match_count,
  output logic                 timeout
);

  localparam int FILL_W = $clog2(PATTERN_W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  if (MAX_BITS < PATTERN_W) begin : g_cfg_check
    $error("pattern_scan_ctrl: MAX_BITS must be >= PATTERN_W");
  end

  state_t                 state_r;
  logic [PATTERN_W-1:0]   pattern_r;
  logic [CNT_W-1:0]       limit_r;
  logic [PATTERN_W-1:0]   history_r;
  logic [FILL_W-1:0]      fill_r;

  logic                   bit_acc_s;
  logic [PATTERN_W-1:0]   hist_next_s;
  logic [FILL_W-1:0]      fill_next_s;
  logic                   hit_s;
  logic [CNT_W-1:0]       cnt_next_s;
  logic                   limit_hit_s;
  logic                   budget_hit_s;

`ifdef SCAN_TIMEOUT_EN
  localparam int BCNT_W = $clog2(MAX_BITS + 1);
  logic [BCNT_W-1:0] bit_cnt_r;

  // Accepted-bit counter, cleared on every accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_r <= '0;
    end else if (state_r == IDLE && start) begin
      bit_cnt_r <= '0;
    end else if (bit_acc_s && !abort) begin
      bit_cnt_r <= bit_cnt_r + BCNT_W'(1);
    end
  end

  // Budget exhausted when the bit taken on this edge is the MAX_BITS-th one.
  always_comb begin
    budget_hit_s = bit_acc_s && ((bit_cnt_r + BCNT_W'(1)) == BCNT_W'(MAX_BITS));
  end
`else
  // Without the timeout feature, scans never end on a bit budget.
  always_comb begin
    budget_hit_s = 1'b0;
  end
`endif

  // Next-value logic for the detector and the match counter.
  always_comb begin
    bit_acc_s   = (state_r == SCAN) && bit_valid;
    hist_next_s = {history_r[PATTERN_W-2:0], bit_in};
    fill_next_s = (fill_r == FILL_W'(PATTERN_W)) ? fill_r : fill_r + FILL_W'(1);
    hit_s       = bit_acc_s && (fill_next_s == FILL_W'(PATTERN_W)) && (hist_next_s == pattern_r);
    cnt_next_s  = (&match_count) ? match_count : match_count + CNT_W'(1);
    limit_hit_s = hit_s && (limit_r != '0) && (cnt_next_s == limit_r);
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      pattern_r   <= '0;
      limit_r     <= '0;
      history_r   <= '0;
      fill_r      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      match       <= 1'b0;
      match_count <= '0;
      timeout     <= 1'b0;
    end else begin
      match <= 1'b0;
      done  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r     <= SCAN;
            busy        <= 1'b1;
            pattern_r   <= pattern;
            limit_r     <= match_limit;
            history_r   <= '0;
            fill_r      <= '0;
            match_count <= '0;
            timeout     <= 1'b0;
          end
        end
        SCAN: begin
          // Abort wins over everything, including a match completed this cycle.
          if (abort) begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end else begin
            if (bit_acc_s) begin
              history_r <= hist_next_s;
              fill_r    <= fill_next_s;
            end
            if (hit_s) begin
              match       <= 1'b1;
              match_count <= cnt_next_s;
            end
            if (limit_hit_s) begin
              state_r <= DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              timeout <= 1'b0;
            end else if (budget_hit_s) begin
              state_r <= DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              timeout <= 1'b1;
            end
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
